// File: rtl/multi_alarm_clock.sv
// Purpose: BCD 24h time-of-day clock with NUM_ALARMS alarm slots and a ring/snooze/ack FSM.
// Latency: time/sec_pulse update on the tick edge; ringing starts one cycle after hh:mm:00; set_err is 1 cycle late.
// Backpressure: none; strobes and ack/snooze are sampled every edge and never stalled.
module multi_alarm_clock #(
  parameter int TICKS_PER_SEC  = 50000000,
  parameter int NUM_ALARMS     = 4,
  parameter int SNOOZE_MIN     = 9,
  parameter int RING_TIMEOUT_S = 60,
  parameter int ID_W           = (NUM_ALARMS > 1) ? $clog2(NUM_ALARMS) : 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            set_time,
  input  logic [7:0]      set_hh,
  input  logic [7:0]      set_mm,
  input  logic [7:0]      set_ss,
  input  logic            set_alarm,
  input  logic [ID_W-1:0] alarm_sel,
  input  logic [7:0]      alarm_hh,
  input  logic [7:0]      alarm_mm,
  input  logic            alarm_en_in,
  input  logic            master_en,
  input  logic            ack,
  input  logic            snooze,
  output logic [7:0]      hours,
  output logic [7:0]      minutes,
  output logic [7:0]      seconds,
  output logic            sec_pulse,
  output logic            alarm_ringing,
  output logic            alarm_snoozed,
  output logic [ID_W-1:0] ring_id,
  output logic            set_err
);

  localparam int PW           = $clog2(TICKS_PER_SEC);
  localparam int RW           = (RING_TIMEOUT_S > 1) ? $clog2(RING_TIMEOUT_S) : 1;
  localparam int SNOOZE_TICKS = SNOOZE_MIN * 60;
  localparam int SW           = $clog2(SNOOZE_TICKS + 1);

  localparam logic [PW-1:0]   PRESC_LAST = PW'(TICKS_PER_SEC - 1);
  localparam logic [RW-1:0]   RING_LAST  = RW'(RING_TIMEOUT_S - 1);
  localparam logic [SW-1:0]   SNZ_LOAD   = SW'(SNOOZE_TICKS);
  localparam logic [ID_W:0]   SLOT_CNT   = (ID_W + 1)'(NUM_ALARMS);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RINGING,
    S_SNOOZED
  } state_t;

  // Both BCD digits legal and the whole value within lim (BCD compares like binary here).
  function automatic logic f_bcd_ok(input logic [7:0] v, input logic [7:0] lim);
    return (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9) && (v <= lim);
  endfunction

  // Per-digit BCD increment that wraps to 00 once lim is reached.
  function automatic logic [7:0] f_bcd_inc(input logic [7:0] v, input logic [7:0] lim);
    if (v == lim)
      return 8'h00;
    if (v[3:0] == 4'd9)
      return {v[7:4] + 4'd1, 4'd0};
    return {v[7:4], v[3:0] + 4'd1};
  endfunction

  logic [PW-1:0]   r_presc;
  logic [7:0]      r_hh, r_mm, r_ss;
  logic            r_sec_pulse;
  logic            r_set_err;
  logic [7:0]      r_al_hh [NUM_ALARMS];
  logic [7:0]      r_al_mm [NUM_ALARMS];
  logic [NUM_ALARMS-1:0] r_al_en;
  state_t          r_state;
  logic [RW-1:0]   r_ring_cnt;
  logic [SW-1:0]   r_snz_cnt;
  logic [ID_W-1:0] r_ring_id;

  logic            w_time_acc;
  logic            w_alarm_acc;
  logic            w_tick;
  logic [7:0]      w_hh_nxt, w_mm_nxt, w_ss_nxt;
  logic [NUM_ALARMS-1:0] w_match;
  logic [ID_W-1:0] w_first;
  logic            w_dis_ring;
  state_t          w_state_nxt;
  logic [RW-1:0]   w_ring_cnt_nxt;
  logic [SW-1:0]   w_snz_cnt_nxt;
  logic [ID_W-1:0] w_ring_id_nxt;

  assign w_time_acc  = set_time && f_bcd_ok(set_hh, 8'h23) && f_bcd_ok(set_mm, 8'h59) &&
                       f_bcd_ok(set_ss, 8'h59);
  assign w_alarm_acc = set_alarm && ({1'b0, alarm_sel} < SLOT_CNT) &&
                       f_bcd_ok(alarm_hh, 8'h23) && f_bcd_ok(alarm_mm, 8'h59);
  // A successful set_time swallows a coincident terminal count.
  assign w_tick      = (r_presc == PRESC_LAST) && !w_time_acc;
  assign w_dis_ring  = w_alarm_acc && !alarm_en_in && (alarm_sel == r_ring_id);

  // Next time-of-day value with seconds->minutes->hours carry chain.
  always_comb begin
    w_ss_nxt = f_bcd_inc(r_ss, 8'h59);
    w_mm_nxt = r_mm;
    w_hh_nxt = r_hh;
    if (r_ss == 8'h59) begin
      w_mm_nxt = f_bcd_inc(r_mm, 8'h59);
      if (r_mm == 8'h59)
        w_hh_nxt = f_bcd_inc(r_hh, 8'h23);
    end
  end

  // Prescaler, time registers, tick pulse and set error flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_presc     <= '0;
      r_hh        <= 8'h00;
      r_mm        <= 8'h00;
      r_ss        <= 8'h00;
      r_sec_pulse <= 1'b0;
      r_set_err   <= 1'b0;
    end else begin
      r_set_err   <= (set_time && !w_time_acc) || (set_alarm && !w_alarm_acc);
      r_sec_pulse <= w_tick;
      if (w_time_acc) begin
        r_presc <= '0;
        r_hh    <= set_hh;
        r_mm    <= set_mm;
        r_ss    <= set_ss;
      end else if (w_tick) begin
        r_presc <= '0;
        r_hh    <= w_hh_nxt;
        r_mm    <= w_mm_nxt;
        r_ss    <= w_ss_nxt;
      end else begin
        r_presc <= r_presc + PW'(1);
      end
    end
  end

  // Alarm slot storage, written only by accepted set_alarm requests.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_al_en <= '0;
      for (int i = 0; i < NUM_ALARMS; i++) begin
        r_al_hh[i] <= 8'h00;
        r_al_mm[i] <= 8'h00;
      end
    end else begin
      for (int i = 0; i < NUM_ALARMS; i++) begin
        if (w_alarm_acc && (alarm_sel == ID_W'(i))) begin
          r_al_hh[i] <= alarm_hh;
          r_al_mm[i] <= alarm_mm;
          r_al_en[i] <= alarm_en_in;
        end
      end
    end
  end

  // Slot match on the registered tick at hh:mm:00, and lowest matching slot index.
  always_comb begin
    w_match = '0;
    w_first = '0;
    for (int i = 0; i < NUM_ALARMS; i++)
      w_match[i] = r_al_en[i] && master_en && r_sec_pulse && (r_ss == 8'h00) &&
                   (r_hh == r_al_hh[i]) && (r_mm == r_al_mm[i]);
    for (int i = NUM_ALARMS - 1; i >= 0; i--)
      if (w_match[i])
        w_first = ID_W'(i);
  end

  // FSM state, ring/snooze timers and latched ring slot.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_ring_cnt <= '0;
      r_snz_cnt  <= '0;
      r_ring_id  <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_ring_cnt <= w_ring_cnt_nxt;
      r_snz_cnt  <= w_snz_cnt_nxt;
      r_ring_id  <= w_ring_id_nxt;
    end
  end

  // FSM next state: ack beats snooze beats timer expiry; master disable or slot disable beats all.
  always_comb begin
    w_state_nxt    = r_state;
    w_ring_cnt_nxt = r_ring_cnt;
    w_snz_cnt_nxt  = r_snz_cnt;
    w_ring_id_nxt  = r_ring_id;
    case (r_state)
      S_IDLE: begin
        if (|w_match) begin
          w_state_nxt    = S_RINGING;
          w_ring_id_nxt  = w_first;
          w_ring_cnt_nxt = '0;
        end
      end
      S_RINGING: begin
        if (ack) begin
          w_state_nxt = S_IDLE;
        end else if (snooze) begin
          w_state_nxt   = S_SNOOZED;
          w_snz_cnt_nxt = SNZ_LOAD;
        end else if (w_tick) begin
          if (r_ring_cnt == RING_LAST)
            w_state_nxt = S_IDLE;
          else
            w_ring_cnt_nxt = r_ring_cnt + RW'(1);
        end
      end
      S_SNOOZED: begin
        if (ack) begin
          w_state_nxt = S_IDLE;
        end else if (r_snz_cnt == '0) begin
          w_state_nxt    = S_RINGING;
          w_ring_cnt_nxt = '0;
        end else if (w_tick) begin
          w_snz_cnt_nxt = r_snz_cnt - SW'(1);
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
    if (!master_en || ((r_state != S_IDLE) && w_dis_ring))
      w_state_nxt = S_IDLE;
  end

  assign hours         = r_hh;
  assign minutes       = r_mm;
  assign seconds       = r_ss;
  assign sec_pulse     = r_sec_pulse;
  assign set_err       = r_set_err;
  assign ring_id       = r_ring_id;
  assign alarm_ringing = (r_state == S_RINGING);
  assign alarm_snoozed = (r_state == S_SNOOZED);

endmodule

// File: tb/tb_multi_alarm_clock.sv
// Purpose: directed scoreboard bench for multi_alarm_clock (TPS=4, 4 slots, 1 min snooze, 5 s timeout).
// Latency: expectations are tagged with the clock cycle at which they must hold.
// Backpressure: none; the monitor compares each cycle whose tag comes due.
module tb_multi_alarm_clock;

  localparam logic [5:0] MT = 6'b000001;  // time
  localparam logic [5:0] MP = 6'b000010;  // sec_pulse
  localparam logic [5:0] MR = 6'b000100;  // alarm_ringing
  localparam logic [5:0] MS = 6'b001000;  // alarm_snoozed
  localparam logic [5:0] MI = 6'b010000;  // ring_id
  localparam logic [5:0] ME = 6'b100000;  // set_err
  localparam logic [5:0] MA = 6'b111111;

  typedef struct packed {
    int          cyc;
    logic [5:0]  m;
    logic [23:0] t;
    logic        p;
    logic        r;
    logic        s;
    logic [1:0]  id;
    logic        e;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       set_time;
  logic [7:0] set_hh, set_mm, set_ss;
  logic       set_alarm;
  logic [1:0] alarm_sel;
  logic [7:0] alarm_hh, alarm_mm;
  logic       alarm_en_in;
  logic       master_en;
  logic       ack;
  logic       snooze;
  logic [7:0] hours, minutes, seconds;
  logic       sec_pulse;
  logic       alarm_ringing;
  logic       alarm_snoozed;
  logic [1:0] ring_id;
  logic       set_err;

  exp_t  eq[$];
  string tq[$];
  event  ev_chk;
  int    cyc = 0;
  int    checks = 0;
  int    errors = 0;
  logic  done = 1'b0;

  multi_alarm_clock #(
    .TICKS_PER_SEC (4),
    .NUM_ALARMS    (4),
    .SNOOZE_MIN    (1),
    .RING_TIMEOUT_S(5)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .set_time     (set_time),
    .set_hh       (set_hh),
    .set_mm       (set_mm),
    .set_ss       (set_ss),
    .set_alarm    (set_alarm),
    .alarm_sel    (alarm_sel),
    .alarm_hh     (alarm_hh),
    .alarm_mm     (alarm_mm),
    .alarm_en_in  (alarm_en_in),
    .master_en    (master_en),
    .ack          (ack),
    .snooze       (snooze),
    .hours        (hours),
    .minutes      (minutes),
    .seconds      (seconds),
    .sec_pulse    (sec_pulse),
    .alarm_ringing(alarm_ringing),
    .alarm_snoozed(alarm_snoozed),
    .ring_id      (ring_id),
    .set_err      (set_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic push(input int c, input string tag, input logic [5:0] m, input logic [23:0] t,
                      input logic p, input logic r, input logic s, input logic [1:0] id,
                      input logic e);
    exp_t x;
    x.cyc = c; x.m = m; x.t = t; x.p = p; x.r = r; x.s = s; x.id = id; x.e = e;
    eq.push_back(x);
    tq.push_back(tag);
  endtask

  task automatic wait_cyc(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic set_t(input logic [23:0] v);
    set_time = 1'b1;
    {set_hh, set_mm, set_ss} = v;
    @(negedge clk);
    set_time = 1'b0;
  endtask

  task automatic set_a(input logic [1:0] sel, input logic [15:0] v, input logic en);
    set_alarm   = 1'b1;
    alarm_sel   = sel;
    {alarm_hh, alarm_mm} = v;
    alarm_en_in = en;
    @(negedge clk);
    set_alarm = 1'b0;
  endtask

  // Monitor: compares every expectation whose cycle has come due.
  initial begin
    exp_t  x;
    string tg;
    logic  ok;
    while (!done) begin
      @(posedge clk or ev_chk);
      #1;
      while (eq.size() > 0 && eq[0].cyc <= cyc) begin
        x  = eq.pop_front();
        tg = tq.pop_front();
        checks++;
        if (x.cyc != cyc) begin
          errors++;
          $display("FAIL %s: expectation for cycle %0d evaluated at cycle %0d", tg, x.cyc, cyc);
        end else begin
          ok = 1'b1;
          if (x.m[0] && ({hours, minutes, seconds} !== x.t)) ok = 1'b0;
          if (x.m[1] && (sec_pulse !== x.p))                  ok = 1'b0;
          if (x.m[2] && (alarm_ringing !== x.r))              ok = 1'b0;
          if (x.m[3] && (alarm_snoozed !== x.s))              ok = 1'b0;
          if (x.m[4] && (ring_id !== x.id))                   ok = 1'b0;
          if (x.m[5] && (set_err !== x.e))                    ok = 1'b0;
          if (!ok) begin
            errors++;
            $display("FAIL %s cyc %0d: got t=%h p=%b r=%b s=%b id=%0d err=%b, want t=%h p=%b r=%b s=%b id=%0d err=%b (mask %b)",
                     tg, cyc, {hours, minutes, seconds}, sec_pulse, alarm_ringing, alarm_snoozed,
                     ring_id, set_err, x.t, x.p, x.r, x.s, x.id, x.e, x.m);
          end
        end
      end
    end
    while (eq.size() > 0) begin
      x  = eq.pop_front();
      tg = tq.pop_front();
      checks++;
      errors++;
      $display("FAIL %s: expectation for cycle %0d never evaluated (run ended at %0d)", tg, x.cyc, cyc);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Watchdog against a stuck run.
  initial begin
    #200000;
    $display("FAIL watchdog: run exceeded time limit at cycle %0d, required completion", cyc);
    $fatal(1, "watchdog");
  end

  // Directed stimulus; each scenario queues its expectations before driving.
  initial begin
    int t;
    rst = 1'b0; set_time = 1'b0; set_hh = '0; set_mm = '0; set_ss = '0;
    set_alarm = 1'b0; alarm_sel = '0; alarm_hh = '0; alarm_mm = '0; alarm_en_in = 1'b0;
    master_en = 1'b1; ack = 1'b0; snooze = 1'b0;

    // Reset state and first tick after release.
    @(negedge clk); @(negedge clk);
    t = cyc;
    push(t + 1, "reset_hold", MA, 24'h000000, 0, 0, 0, 0, 0);
    @(negedge clk);
    rst = 1'b1;
    t = cyc;
    push(t + 1, "reset_release", MA, 24'h000000, 0, 0, 0, 0, 0);
    push(t + 3, "no_early_tick", MT | MP, 24'h000000, 0, 0, 0, 0, 0);
    push(t + 4, "first_tick", MT | MP, 24'h000001, 1, 0, 0, 0, 0);
    push(t + 5, "pulse_width", MP, 24'h0, 0, 0, 0, 0, 0);
    wait_cyc(t + 5);

    // Rollover through midnight; prescaler restarts at set.
    t = cyc;
    push(t + 1, "set_load", MT | MP | ME, 24'h235958, 0, 0, 0, 0, 0);
    push(t + 4, "presc_restart", MT | MP, 24'h235958, 0, 0, 0, 0, 0);
    push(t + 5, "tick_59", MT | MP, 24'h235959, 1, 0, 0, 0, 0);
    push(t + 6, "pulse_drop", MP, 24'h0, 0, 0, 0, 0, 0);
    push(t + 9, "rollover", MT | MP, 24'h000000, 1, 0, 0, 0, 0);
    set_t(24'h235958);
    wait_cyc(t + 9);

    // Rejected set requests pulse set_err and leave time running untouched.
    t = cyc;
    push(t + 1, "bad_mm_err", MT | ME, 24'h000000, 0, 0, 0, 0, 1);
    push(t + 2, "err_pulse", ME, 24'h0, 0, 0, 0, 0, 0);
    push(t + 3, "bad_alarm_err", MT | ME, 24'h000000, 0, 0, 0, 0, 1);
    push(t + 4, "time_kept", MT | MP | ME, 24'h000001, 1, 0, 0, 0, 0);
    push(t + 5, "bad_hh_err", MT | ME, 24'h000001, 0, 0, 0, 0, 1);
    push(t + 6, "err_clear", ME | MR, 24'h0, 0, 0, 0, 0, 0);
    set_t(24'h126000);
    wait_cyc(t + 2);
    set_a(2'd0, 16'h1A00, 1'b1);
    wait_cyc(t + 4);
    set_t(24'h240000);
    wait_cyc(t + 6);
    set_a(2'd0, 16'h0700, 1'b0);
    set_a(2'd1, 16'h0700, 1'b1);
    set_a(2'd3, 16'h0700, 1'b1);
    set_a(2'd2, 16'h0701, 1'b1);

    // Multi-match: slots 1 and 3 at 07:00, lowest wins; unacknowledged ring times out.
    t = cyc;
    push(t + 1, "mm_load", MT | MP | ME, 24'h065959, 0, 0, 0, 0, 0);
    push(t + 5, "mm_tick", MT | MP | MR, 24'h070000, 1, 0, 0, 0, 0);
    push(t + 6, "mm_ring", MR | MS | MI, 24'h0, 0, 1, 0, 1, 0);
    push(t + 24, "ring_hold", MR, 24'h0, 0, 1, 0, 0, 0);
    push(t + 25, "ring_timeout", MT | MR, 24'h070005, 0, 0, 0, 0, 0);
    set_t(24'h065959);
    wait_cyc(t + 26);

    // Snooze for 60 ticks, re-ring with same slot, then ack.
    t = cyc;
    push(t + 6, "sn_ring", MR | MI, 24'h0, 0, 1, 0, 1, 0);
    push(t + 7, "sn_pre", MR | MS, 24'h0, 0, 1, 0, 0, 0);
    push(t + 8, "snoozed", MR | MS, 24'h0, 0, 0, 1, 0, 0);
    push(t + 100, "snooze_mid", MR | MS, 24'h0, 0, 0, 1, 0, 0);
    push(t + 245, "snooze_last", MT | MR | MS, 24'h070100, 0, 0, 1, 0, 0);
    push(t + 246, "re_ring", MR | MS | MI, 24'h0, 0, 1, 0, 1, 0);
    push(t + 247, "re_ring_hold", MR, 24'h0, 0, 1, 0, 0, 0);
    push(t + 248, "ack_idle", MR | MS, 24'h0, 0, 0, 0, 0, 0);
    set_t(24'h065959);
    wait_cyc(t + 7);
    snooze = 1'b1;
    @(negedge clk);
    snooze = 1'b0;
    wait_cyc(t + 247);
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
    wait_cyc(t + 249);

    // ack and snooze together: ack wins.
    t = cyc;
    push(t + 6, "pa_ring", MR | MI, 24'h0, 0, 1, 0, 1, 0);
    push(t + 7, "ack_over_snooze", MR | MS, 24'h0, 0, 0, 0, 0, 0);
    push(t + 8, "ack_stays_idle", MR | MS, 24'h0, 0, 0, 0, 0, 0);
    set_t(24'h065959);
    wait_cyc(t + 6);
    ack = 1'b1;
    snooze = 1'b1;
    @(negedge clk);
    ack = 1'b0;
    snooze = 1'b0;
    wait_cyc(t + 9);

    // master_en dropped while snoozed.
    t = cyc;
    push(t + 6, "pb_ring", MR, 24'h0, 0, 1, 0, 0, 0);
    push(t + 7, "pb_snoozed", MR | MS, 24'h0, 0, 0, 1, 0, 0);
    push(t + 8, "pb_snz_hold", MR | MS, 24'h0, 0, 0, 1, 0, 0);
    push(t + 9, "master_off", MR | MS, 24'h0, 0, 0, 0, 0, 0);
    set_t(24'h065959);
    wait_cyc(t + 6);
    snooze = 1'b1;
    @(negedge clk);
    snooze = 1'b0;
    wait_cyc(t + 8);
    master_en = 1'b0;
    @(negedge clk);
    master_en = 1'b1;
    wait_cyc(t + 10);

    // Disabling the ringing slot stops the ring.
    t = cyc;
    push(t + 6, "pc_ring", MR | MI, 24'h0, 0, 1, 0, 1, 0);
    push(t + 7, "pc_pre", MR | ME, 24'h0, 0, 1, 0, 0, 0);
    push(t + 8, "slot_disable", MR | MS | ME, 24'h0, 0, 0, 0, 0, 0);
    set_t(24'h065959);
    wait_cyc(t + 7);
    set_a(2'd1, 16'h0700, 1'b0);
    wait_cyc(t + 9);

    // Only slot 3 left; async reset mid-ring clears everything at once.
    t = cyc;
    push(t + 6, "rst_ring", MR | MI, 24'h0, 0, 1, 0, 3, 0);
    push(t + 7, "rst_pre", MR | MI, 24'h0, 0, 1, 0, 3, 0);
    set_t(24'h065959);
    wait_cyc(t + 7);
    rst = 1'b0;
    #1;
    push(t + 7, "async_rst", MA, 24'h000000, 0, 0, 0, 0, 0);
    -> ev_chk;
    push(t + 8, "rst_held", MA, 24'h000000, 0, 0, 0, 0, 0);
    @(negedge clk);
    rst = 1'b1;
    push(t + 9, "rst_out", MA, 24'h000000, 0, 0, 0, 0, 0);
    push(t + 10, "post_set", MT, 24'h065959, 0, 0, 0, 0, 0);
    push(t + 14, "post_tick", MT | MP, 24'h070000, 1, 0, 0, 0, 0);
    push(t + 15, "no_ring", MR | MS | MI, 24'h0, 0, 0, 0, 0, 0);
    push(t + 19, "still_quiet", MR | MS, 24'h0, 0, 0, 0, 0, 0);
    wait_cyc(t + 9);
    set_t(24'h065959);
    wait_cyc(t + 21);
    done = 1'b1;
  end

endmodule
